// File: rtl/pic_master.sv
// 8-input 8259A-subset interrupt controller: IRQ edge capture, fixed priority with ISR nesting,
// toggle-handshake vector delivery. Define PIC_AEOI_EN for automatic EOI (ISR never set).
module pic_master #(
    parameter logic [15:0] BASE_PORT    = 16'h0020,
    parameter logic [7:0]  VECTOR_RESET = 8'h08
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        port_clk,
    input  logic [15:0] port,
    input  logic [7:0]  port_o,
    input  logic        port_w,
    output logic [7:0]  port_i,
    input  logic [7:0]  irq_in,
    output logic        intr,
    output logic [7:0]  irq,
    input  logic        intr_latch
);

`ifdef PIC_AEOI_EN
    localparam bit AEOI = 1'b1;
`else
    localparam bit AEOI = 1'b0;
`endif

    // Handshake: a vector is offered while intr != intr_latch; the CPU accepts it by
    // copying intr into intr_latch, after which the controller returns to IDLE.
    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t     state;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [7:0] imr;
    logic [7:0] base;
    logic [7:0] irq_prev;
    logic       read_sel;      // 0 selects IRR, 1 selects ISR on command-port reads
    logic       icw_step;

    logic cmd_hit, data_hit;
    logic cmd_wr, data_wr, cmd_rd, data_rd;
    logic icw1_wr, ocw3_wr, ocw2_wr;
    logic eoi_ns, eoi_sp;

    assign cmd_hit  = port_clk && (port == BASE_PORT);
    assign data_hit = port_clk && (port == BASE_PORT + 16'd1);
    assign cmd_wr   = cmd_hit && port_w;
    assign data_wr  = data_hit && port_w;
    assign cmd_rd   = cmd_hit && !port_w;
    assign data_rd  = data_hit && !port_w;
    assign icw1_wr  = cmd_wr && port_o[4];
    assign ocw3_wr  = cmd_wr && !port_o[4] && port_o[3];
    assign ocw2_wr  = cmd_wr && !port_o[4] && !port_o[3];
    assign eoi_ns   = ocw2_wr && (port_o[7:5] == 3'b001);
    assign eoi_sp   = ocw2_wr && (port_o[7:5] == 3'b011);

    // An in-service level blocks itself and every lower-priority level.
    logic       found;
    logic       blocked;
    logic [2:0] sel_n;

    always_comb begin
        found   = 1'b0;
        blocked = 1'b0;
        sel_n   = 3'd0;
        for (int n = 0; n < 8; n++) begin
            if (!AEOI && isr[n]) begin
                blocked = 1'b1;
            end
            if (!blocked && !found && irr[n] && !imr[n]) begin
                found = 1'b1;
                sel_n = 3'(n);
            end
        end
    end

    logic       deliver;
    logic [7:0] edges;
    logic [7:0] irr_next;
    logic [7:0] isr_next;
    logic [7:0] isr_lowbit;

    assign deliver    = (state == IDLE) && found && !icw1_wr;
    assign edges      = irq_in & ~irq_prev;
    assign isr_lowbit = isr & (~isr + 8'd1);

    always_comb begin
        irr_next = irr;
        isr_next = isr;
        if (!AEOI && eoi_ns) begin
            isr_next = isr_next & ~isr_lowbit;
        end
        if (!AEOI && eoi_sp) begin
            isr_next[port_o[2:0]] = 1'b0;
        end
        if (deliver) begin
            irr_next[sel_n] = 1'b0;
            if (!AEOI) begin
                isr_next[sel_n] = 1'b1;
            end
        end
        if (icw1_wr) begin
            irr_next = 8'h00;
            isr_next = 8'h00;
        end
        // A fresh edge survives any clear landing in the same cycle.
        irr_next = irr_next | edges;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            irr      <= 8'h00;
            isr      <= 8'h00;
            imr      <= 8'h00;
            base     <= VECTOR_RESET;
            irq_prev <= 8'h00;
            read_sel <= 1'b0;
            icw_step <= 1'b0;
            port_i   <= 8'h00;
            irq      <= 8'h00;
            intr     <= intr_latch;
        end else begin
            irq_prev <= irq_in;
            irr      <= irr_next;
            isr      <= isr_next;

            case (state)
                IDLE: begin
                    if (deliver) begin
                        irq   <= base | {5'b00000, sel_n};
                        intr  <= ~intr_latch;
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (intr_latch == intr) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (icw1_wr) begin
                imr      <= 8'h00;
                read_sel <= 1'b0;
                icw_step <= 1'b1;
            end else if (ocw3_wr) begin
                if (port_o[1:0] == 2'b10) begin
                    read_sel <= 1'b0;
                end else if (port_o[1:0] == 2'b11) begin
                    read_sel <= 1'b1;
                end
            end

            if (data_wr) begin
                if (icw_step) begin
                    base     <= port_o & 8'hF8;
                    icw_step <= 1'b0;
                end else begin
                    imr <= port_o;
                end
            end

            if (cmd_rd) begin
                port_i <= read_sel ? isr : irr;
            end else if (data_rd) begin
                port_i <= imr;
            end
        end
    end

endmodule
